rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL: parameters, one per line:
- XLEN, default 32, data width.
- RAW, default 5, register address width.
REQ-002 SHALL: ports, one per line:
- clk  in  1  clock, rising edge; reset rst, asynchronous, active-high.
- rst  in  1  asynchronous active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  RAW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load writeback request.
- mem_addr  in  RAW  load destination register.
- mem_data  in  XLEN  load result.
- mem_ready  out  1  load request accepted this cycle.
- iss_valid  in  1  instruction issued with destination.
- iss_addr  in  RAW  issued destination register.
- chk_addr_a  in  RAW  source A to hazard-check.
- chk_addr_b  in  RAW  source B to hazard-check.
- busy_a  out  1  chk_addr_a has a pending write.
- busy_b  out  1  chk_addr_b has a pending write.
- wr_en  out  1  register-file write enable (L_S).
- wr_addr  out  RAW  register-file write address.
- wr_data  out  XLEN  register-file write data.

Function
REQ-003 SHALL: single write port shared by ALU and MEM requesters; at most one grant per cycle.
REQ-004 SHALL: xxx_ready combinational from valids and priority pointer; transfer occurs when valid && ready at clk edge.
REQ-005 SHALL: only one valid -> that requester granted.
REQ-006 SHALL: both valid -> requester named by 1-bit round-robin pointer granted; pointer toggles to the other requester after every arbitrated (both-valid) grant, unchanged otherwise.
REQ-007 SHALL: requester not granted keeps valid/addr/data stable until ready (requester obligation; bench asserts).
REQ-008 SHALL: wr_en/wr_addr/wr_data registered, one cycle after grant edge (latency 1); wr_en low in cycles with no grant.
REQ-009 SHALL: grant with addr 0 -> accepted (ready high), wr_en stays 0, scoreboard untouched.
REQ-010 SHALL: scoreboard of 31 pending bits (r1-r31); iss_valid with iss_addr!=0 sets bit at edge.
REQ-011 SHALL: granted nonzero addr clears its bit at grant edge.
REQ-012 SHALL: same-edge set and clear of same register -> set wins (newer producer pending).
REQ-013 SHALL: busy_a/busy_b combinational = pending bit of addr, OR'ed with (registered wr_en && wr_addr==chk addr) is NOT applied; addr 0 always 0.
REQ-014 SHALL: iss_valid to an already-pending register is legal; bit stays set.

Reset
REQ-015 SHALL: rst asynchronously clears wr_en, wr_addr, wr_data to 0, all pending bits to 0, pointer to ALU.
REQ-016 SHALL: rst mid-operation discards in-flight grant; first write after deassertion only from new valid.
REQ-017 SHALL: ready outputs remain combinational during reset but no state updates.

Structure
REQ-018 SHALL: XLEN, RAW, register count 32 and requester encoding (ALU=0, MEM=1) in shared package/header.
REQ-019 SHALL: 2-way round-robin arbiter as sub-module rr_arb2 (req[1:0] -> gnt[1:0], pointer inside).

Verification
REQ-020 SHALL: alu_valid only, addr 5, data 0x11 -> alu_ready=1; next cycle wr_en=1, wr_addr=5, wr_data=0x11.
REQ-021 SHALL: after reset both valid (ALU r3=0xA, MEM r4=0xB) held -> cycle1 ALU granted, cycle2 MEM granted; writes r3 then r4 on consecutive cycles.
REQ-022 SHALL: iss r7, then chk_addr_a=7 -> busy_a=1 until ALU grant of r7; busy_a=0 next cycle.
REQ-023 SHALL: same edge iss r9 and MEM grant r9 -> r9 pending stays 1.
REQ-024 SHALL: MEM grant addr 0 -> mem_ready=1, wr_en=0 next cycle, busy_b (chk 0)=0.
REQ-025 SHALL: rst asserted mid-cycle with r2 pending and grant outstanding -> wr_en=0, busy for r2=0 immediately.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared sizing and requester encoding for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;
    localparam int NREGS    = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only advances on contested cycles.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_e ptr_r;

    // grant selection from requests and pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_r == REQ_ALU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // pointer hands priority to the loser of each contested cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= REQ_ALU;
        end else if (req == 2'b11) begin
            ptr_r <= (ptr_r == REQ_ALU) ? REQ_MEM : REQ_ALU;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between ALU and load
// results and tracks pending destination registers for hazard checks.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [RAW-1:0]  alu_addr,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [RAW-1:0]  mem_addr,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            iss_valid,
    input  logic [RAW-1:0]  iss_addr,
    input  logic [RAW-1:0]  chk_addr_a,
    input  logic [RAW-1:0]  chk_addr_b,
    output logic            busy_a,
    output logic            busy_b,
    output logic            wr_en,
    output logic [RAW-1:0]  wr_addr,
    output logic [XLEN-1:0] wr_data
);

    logic [1:0]       gnt_s;
    logic             grant_s;
    logic [RAW-1:0]   sel_addr_s;
    logic [XLEN-1:0]  sel_data_s;
    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] pending_s;
    logic             wr_en_r;
    logic [RAW-1:0]   wr_addr_r;
    logic [XLEN-1:0]  wr_data_r;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({mem_valid, alu_valid}),
        .gnt (gnt_s)
    );

    assign alu_ready = gnt_s[REQ_ALU];
    assign mem_ready = gnt_s[REQ_MEM];
    assign grant_s   = |gnt_s;

    // winning requester's address and data
    always_comb begin
        sel_addr_s = {RAW{1'b0}};
        sel_data_s = {XLEN{1'b0}};
        if (gnt_s[REQ_MEM]) begin
            sel_addr_s = mem_addr;
            sel_data_s = mem_data;
        end else if (gnt_s[REQ_ALU]) begin
            sel_addr_s = alu_addr;
            sel_data_s = alu_data;
        end else begin
            sel_addr_s = {RAW{1'b0}};
            sel_data_s = {XLEN{1'b0}};
        end
    end

    // scoreboard next state: clear first so a same-edge issue keeps the bit set
    always_comb begin
        pending_s = pending_r;
        if (grant_s) begin
            pending_s[sel_addr_s] = 1'b0;
        end else begin
            pending_s = pending_r;
        end
        if (iss_valid) begin
            pending_s[iss_addr] = 1'b1;
        end else begin
            pending_s[iss_addr] = pending_s[iss_addr];
        end
        pending_s[0] = 1'b0;
    end

    // pending-register scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {NREGS{1'b0}};
        end else begin
            pending_r <= pending_s;
        end
    end

    // registered write port; writes to r0 are accepted but suppressed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {RAW{1'b0}};
            wr_data_r <= {XLEN{1'b0}};
        end else if (grant_s) begin
            wr_en_r   <= (sel_addr_s != {RAW{1'b0}});
            wr_addr_r <= sel_addr_s;
            wr_data_r <= sel_data_s;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

    assign busy_a = (chk_addr_a != {RAW{1'b0}}) && pending_r[chk_addr_a];
    assign busy_b = (chk_addr_b != {RAW{1'b0}}) && pending_r[chk_addr_b];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus constrained-random bench for rf_wb_arbiter with an expected-write queue.
module tb_rf_wb_arbiter;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, mem_valid, iss_valid;
    logic [RAW-1:0]  alu_addr, mem_addr, iss_addr, chk_addr_a, chk_addr_b;
    logic [XLEN-1:0] alu_data, mem_data;
    logic            alu_ready, mem_ready, busy_a, busy_b, wr_en;
    logic [RAW-1:0]  wr_addr;
    logic [XLEN-1:0] wr_data;

    typedef struct {
        logic            en;
        logic [RAW-1:0]  addr;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t   exp_q[$];
    int    passed = 0;
    int    total  = 0;
    logic  m_ptr;
    logic [31:0] m_pend;
    logic  last_ar, last_mr;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .busy_a(busy_a), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: check combinational outputs, predict, clock, then check the write port.
    task automatic tick();
        logic ar, mr;
        wr_t  w, got;
        #1;
        if (alu_valid && mem_valid) begin
            ar = (m_ptr == 1'b0);
            mr = (m_ptr == 1'b1);
        end else begin
            ar = alu_valid;
            mr = mem_valid;
        end
        chk("alu_ready", 64'(alu_ready), 64'(ar));
        chk("mem_ready", 64'(mem_ready), 64'(mr));
        chk("busy_a", 64'(busy_a), 64'((chk_addr_a != 5'd0) && m_pend[chk_addr_a]));
        chk("busy_b", 64'(busy_b), 64'((chk_addr_b != 5'd0) && m_pend[chk_addr_b]));
        w.en = 1'b0; w.addr = 5'd0; w.data = 32'd0;
        if (ar) begin
            w.en = (alu_addr != 5'd0); w.addr = alu_addr; w.data = alu_data;
        end else if (mr) begin
            w.en = (mem_addr != 5'd0); w.addr = mem_addr; w.data = mem_data;
        end
        exp_q.push_back(w);
        if (alu_valid && mem_valid) m_ptr = ~m_ptr;
        if (ar || mr) m_pend[w.addr] = 1'b0;
        if (iss_valid) m_pend[iss_addr] = 1'b1;
        m_pend[0] = 1'b0;
        last_ar = ar;
        last_mr = mr;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("wr_en", 64'(wr_en), 64'(got.en));
        if (got.en) begin
            chk("wr_addr", 64'(wr_addr), 64'(got.addr));
            chk("wr_data", 64'(wr_data), 64'(got.data));
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
        alu_addr = 5'd0; mem_addr = 5'd0; iss_addr = 5'd0;
        alu_data = 32'd0; mem_data = 32'd0;
    endtask

    initial begin
        idle();
        chk_addr_a = 5'd0; chk_addr_b = 5'd0;
        m_ptr = 1'b0; m_pend = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        alu_valid = 1'b1; alu_addr = 5'd1;
        #1;
        chk("rst_comb_ready", 64'(alu_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("rst_no_write", 64'(wr_en), 64'd0);
        idle();
        rst = 1'b0;

        // single ALU request
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
        tick();
        idle();
        tick();

        // contested, then MEM alone, then contested again with pointer at MEM
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'hB;
        tick();
        chk("arb_first_alu", 64'(last_ar), 64'd1);
        alu_valid = 1'b0;
        tick();
        chk("arb_then_mem", 64'(last_mr), 64'd1);
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'hC;
        mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'hD;
        tick();
        mem_valid = 1'b0;
        tick();
        idle();

        // hazard on r7 until the ALU writes it back
        chk_addr_a = 5'd7;
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        tick();
        iss_valid = 1'b0;
        tick();
        chk("busy_a_r7_set", 64'(busy_a), 64'd1);
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        #1;
        chk("busy_a_r7_clear", 64'(busy_a), 64'd0);
        tick();

        // same-edge issue and MEM writeback of r9
        chk_addr_b = 5'd9;
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
        tick();
        idle();
        #1;
        chk("busy_b_r9_set_wins", 64'(busy_b), 64'd1);
        tick();

        // MEM write to r0 is accepted but not performed
        chk_addr_b = 5'd0;
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h55;
        tick();
        idle();
        chk("r0_no_write", 64'(wr_en), 64'd0);
        tick();

        // random traffic; requesters hold until accepted
        for (int i = 0; i < 60; i++) begin
            if (!alu_valid || last_ar) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_addr  = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!mem_valid || last_mr) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_addr  = 5'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            iss_valid  = 1'($urandom_range(0, 1));
            iss_addr   = 5'($urandom_range(0, 31));
            chk_addr_a = 5'($urandom_range(0, 31));
            chk_addr_b = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        tick();

        // reset in the middle of an outstanding write with r2 pending
        chk_addr_a = 5'd2;
        iss_valid = 1'b1; iss_addr = 5'd2;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h66;
        @(posedge clk);
        #1;
        chk("pre_rst_wr_en", 64'(wr_en), 64'd1);
        chk("pre_rst_busy_r2", 64'(busy_a), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_busy_r2", 64'(busy_a), 64'd0);
        chk("mid_rst_ready", 64'(alu_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("rst_hold_wr_en", 64'(wr_en), 64'd0);
        exp_q.delete();
        idle();
        m_ptr = 1'b0; m_pend = 32'd0;
        rst = 1'b0;
        tick();
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h1234;
        tick();
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
